// File: rtl/vga_pkg.sv
// Shared types and screen geometry for the guess-who VGA game.
// Game-state one-hot encoding, result codes and portrait grid layout.
package vga_pkg;

  typedef enum logic [5:0] {
    S_START   = 6'b000001,
    S_GUESS   = 6'b000010,
    S_CHECK   = 6'b000100,
    S_WIN     = 6'b001000,
    S_LOSE    = 6'b010000,
    S_RESTART = 6'b100000
  } game_state_t;

  localparam logic [1:0] RESULT_WIN  = 2'b10;
  localparam logic [1:0] RESULT_LOSE = 2'b01;

  localparam logic [11:0] X_1_DIM = 12'd100;
  localparam logic [11:0] X_2_DIM = 12'd300;
  localparam logic [11:0] X_3_DIM = 12'd500;
  localparam logic [11:0] Y_1_DIM = 12'd100;
  localparam logic [11:0] Y_2_DIM = 12'd300;
  localparam logic [11:0] Y_3_DIM = 12'd500;
  localparam logic [11:0] A_side  = 12'd150;
  localparam logic [11:0] B_side  = 12'd150;

endpackage

// File: rtl/game_state_ctrl_tile_hit_decoder.sv
// Combinational 3x3 portrait hit test.
// Ports: xpos_i/ypos_i mouse position; tile_idx_o 1..9 on hit, 0 otherwise.
module tile_hit_decoder
  import vga_pkg::*;
(
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  output logic [3:0]  tile_idx_o
);

  function automatic logic in_rng(
    input logic [11:0] v,
    input logic [11:0] lo,
    input logic [11:0] len
  );
    return ({1'b0, v} >= {1'b0, lo}) &&
           ({1'b0, v} <= ({1'b0, lo} + {1'b0, len}));
  endfunction

  logic [2:0] col_hit;
  logic [2:0] row_hit;

  assign col_hit = {in_rng(xpos_i, X_3_DIM, A_side),
                    in_rng(xpos_i, X_2_DIM, A_side),
                    in_rng(xpos_i, X_1_DIM, A_side)};
  assign row_hit = {in_rng(ypos_i, Y_3_DIM, B_side),
                    in_rng(ypos_i, Y_2_DIM, B_side),
                    in_rng(ypos_i, Y_1_DIM, B_side)};

  // Scan high to low so the lowest overlapping index wins.
  always_comb begin
    tile_idx_o = '0;
    for (int n = 8; n >= 0; n--) begin
      if (row_hit[n / 3] && col_hit[n % 3]) begin
        tile_idx_o = 4'(n + 1);
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Guess-who game sequencer: person select, guess, result, restart.
// Ports: clk/rst, mouse xpos/ypos/buttons, resoult/reset in; state_bin, your_person, rst_sys out.
module game_state_ctrl
  import vga_pkg::*;
#(
  parameter int CHECK_TIMEOUT = 65_000_000,
  parameter int RST_PULSE_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        MouseLeft,
  input  logic        MouseRight,
  input  logic [1:0]  resoult,
  input  logic        reset,
  output logic [5:0]  state_bin,
  output logic [3:0]  your_person,
  output logic        rst_sys
);

  localparam int CW = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;
  localparam int RW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_LEN - 1);

  game_state_t   state_q, state_d;
  logic [3:0]    person_q, person_d;
  logic [CW-1:0] chk_cnt_q, chk_cnt_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          rst_sys_q, rst_sys_d;
  logic          ml_q, mr_q;
  logic          l_click, r_click;
  logic [3:0]    tile_idx;

  tile_hit_decoder u_hit (
    .xpos_i     (xpos),
    .ypos_i     (ypos),
    .tile_idx_o (tile_idx)
  );

  assign l_click = MouseLeft & ~ml_q;
  assign r_click = MouseRight & ~mr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_START;
      person_q  <= '0;
      chk_cnt_q <= '0;
      rst_cnt_q <= '0;
      rst_sys_q <= 1'b0;
      ml_q      <= 1'b0;
      mr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      person_q  <= person_d;
      chk_cnt_q <= chk_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      rst_sys_q <= rst_sys_d;
      ml_q      <= MouseLeft;
      mr_q      <= MouseRight;
    end
  end

  always_comb begin
    state_d   = state_q;
    person_d  = person_q;
    chk_cnt_d = chk_cnt_q;
    rst_cnt_d = rst_cnt_q;
    // Our own pulse echoes back through the peer; ignore it in RESTART.
    if (reset && state_q != S_RESTART) begin
      state_d   = S_START;
      person_d  = '0;
      chk_cnt_d = '0;
      rst_cnt_d = '0;
    end else begin
      case (state_q)
        S_START: begin
          if (l_click && tile_idx != 4'd0) begin
            person_d = tile_idx;
            state_d  = S_GUESS;
          end
        end
        S_GUESS: begin
          if (resoult == RESULT_WIN) begin
            state_d = S_WIN;
          end else if (resoult == RESULT_LOSE) begin
            state_d = S_LOSE;
          end else if (r_click && tile_idx != 4'd0) begin
            state_d   = S_CHECK;
            chk_cnt_d = '0;
          end
        end
        S_CHECK: begin
          if (resoult == RESULT_WIN) begin
            state_d = S_WIN;
          end else if (resoult == RESULT_LOSE) begin
            state_d = S_LOSE;
          end else if (chk_cnt_q == CHK_LAST) begin
            state_d   = S_GUESS;
            chk_cnt_d = '0;
          end else begin
            chk_cnt_d = chk_cnt_q + CW'(1);
          end
        end
        S_WIN, S_LOSE: begin
          if (l_click) begin
            state_d   = S_RESTART;
            rst_cnt_d = '0;
          end
        end
        S_RESTART: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = S_START;
            person_d  = '0;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        default: begin
          state_d   = S_START;
          person_d  = '0;
          chk_cnt_d = '0;
          rst_cnt_d = '0;
        end
      endcase
    end
    rst_sys_d = (state_d == S_RESTART);
  end

  assign state_bin   = state_q;
  assign your_person = person_q;
  assign rst_sys     = rst_sys_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl.
// Small CHECK_TIMEOUT / RST_PULSE_LEN to keep runs short.
module tb_game_state_ctrl;
  import vga_pkg::*;

  localparam logic [5:0] ST_START   = 6'b000001;
  localparam logic [5:0] ST_GUESS   = 6'b000010;
  localparam logic [5:0] ST_CHECK   = 6'b000100;
  localparam logic [5:0] ST_WIN     = 6'b001000;
  localparam logic [5:0] ST_LOSE    = 6'b010000;
  localparam logic [5:0] ST_RESTART = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        MouseLeft, MouseRight;
  logic [1:0]  resoult;
  logic        reset;
  logic [5:0]  state_bin;
  logic [3:0]  your_person;
  logic        rst_sys;

  int total = 0;
  int bad   = 0;

  game_state_ctrl #(
    .CHECK_TIMEOUT (8),
    .RST_PULSE_LEN (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .xpos        (xpos),
    .ypos        (ypos),
    .MouseLeft   (MouseLeft),
    .MouseRight  (MouseRight),
    .resoult     (resoult),
    .reset       (reset),
    .state_bin   (state_bin),
    .your_person (your_person),
    .rst_sys     (rst_sys)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [5:0] exp);
    total++;
    if (state_bin !== exp) begin
      bad++;
      $display("FAIL %s state_bin got %b want %b", nm, state_bin, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; reset = 1'b0; resoult = 2'b00;
    MouseLeft = 1'b0; MouseRight = 1'b0;
    xpos = 12'd0; ypos = 12'd0;
    step(); step();
    rst = 1'b0;
    chk_state("reset", ST_START);
    total++;
    if (your_person !== 4'd0) begin
      bad++; $display("FAIL reset_person got %0d want 0", your_person);
    end
    total++;
    if (rst_sys !== 1'b0) begin
      bad++; $display("FAIL reset_rst_sys got %b want 0", rst_sys);
    end
    // Edge off-grid, then slide onto a tile with button held.
    MouseLeft = 1'b1;
    step();
    xpos = X_2_DIM + 12'd1; ypos = Y_3_DIM + 12'd1;
    step(); step(); step();
    chk_state("held_no_edge", ST_START);
    MouseLeft = 1'b0;
    step();
  endtask

  task automatic test_select();
    // Gap between columns 1 and 2 is not a tile.
    xpos = X_1_DIM + A_side + 12'd1; ypos = Y_1_DIM;
    MouseLeft = 1'b1; step();
    chk_state("gap_click", ST_START);
    MouseLeft = 1'b0; step();
    xpos = 12'd0; ypos = 12'd0;
    MouseLeft = 1'b1; step();
    chk_state("origin_click", ST_START);
    MouseLeft = 1'b0; step();
    xpos = X_2_DIM + 12'd1; ypos = Y_3_DIM + 12'd1;
    MouseLeft = 1'b1; step();
    chk_state("select", ST_GUESS);
    total++;
    if (your_person !== 4'd8) begin
      bad++; $display("FAIL select_person got %0d want 8", your_person);
    end
    MouseLeft = 1'b0; step();
  endtask

  task automatic test_guess_win();
    // Inclusive far corner of tile 5.
    xpos = X_2_DIM + A_side; ypos = Y_2_DIM + B_side;
    MouseRight = 1'b1; step();
    chk_state("guess_to_check", ST_CHECK);
    MouseRight = 1'b0;
    step(); step();
    chk_state("check_hold", ST_CHECK);
    resoult = RESULT_WIN; step();
    resoult = 2'b00;
    chk_state("check_win", ST_WIN);
    total++;
    if (your_person !== 4'd8) begin
      bad++; $display("FAIL win_person got %0d want 8", your_person);
    end
  endtask

  task automatic test_restart();
    int hi;
    hi = 0;
    xpos = 12'd0; ypos = 12'd0;
    MouseLeft = 1'b1; step();
    MouseLeft = 1'b0;
    chk_state("restart_enter", ST_RESTART);
    if (rst_sys === 1'b1) hi++;
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 2) reset = 1'b0;
      if (rst_sys === 1'b1) hi++;
    end
    total++;
    if (hi != 4) begin
      bad++; $display("FAIL rst_sys_len got %0d want 4", hi);
    end
    chk_state("restart_done", ST_START);
    total++;
    if (your_person !== 4'd0) begin
      bad++; $display("FAIL restart_person got %0d want 0", your_person);
    end
  endtask

  task automatic select_tile1();
    xpos = X_1_DIM; ypos = Y_1_DIM;
    MouseLeft = 1'b1; step();
    MouseLeft = 1'b0; step();
    chk_state("sel1", ST_GUESS);
    total++;
    if (your_person !== 4'd1) begin
      bad++; $display("FAIL sel1_person got %0d want 1", your_person);
    end
  endtask

  task automatic test_timeout();
    select_tile1();
    xpos = X_2_DIM + 12'd5; ypos = Y_2_DIM + 12'd5;
    MouseRight = 1'b1; step();
    MouseRight = 1'b0;
    chk_state("to_enter", ST_CHECK);
    for (int i = 1; i <= 6; i++) step();
    step();
    chk_state("to_cycle7", ST_CHECK);
    step();
    chk_state("to_cycle8", ST_GUESS);
  endtask

  task automatic test_peer_lose();
    xpos = X_2_DIM + 12'd5; ypos = Y_2_DIM + 12'd5;
    MouseRight = 1'b1; resoult = RESULT_LOSE; step();
    MouseRight = 1'b0; resoult = 2'b00;
    chk_state("peer_lose", ST_LOSE);
    reset = 1'b1; step();
    reset = 1'b0;
    chk_state("lose_peer_reset", ST_START);
  endtask

  task automatic test_peer_reset();
    select_tile1();
    reset = 1'b1; step();
    reset = 1'b0;
    chk_state("guess_peer_reset", ST_START);
    total++;
    if (your_person !== 4'd0) begin
      bad++; $display("FAIL peer_person got %0d want 0", your_person);
    end
  endtask

  task automatic test_rst_mid();
    select_tile1();
    rst = 1'b1; step();
    rst = 1'b0;
    chk_state("rst_mid", ST_START);
    total++;
    if (your_person !== 4'd0 || rst_sys !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_out got %0d/%b want 0/0", your_person, rst_sys);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_guess_win();
    test_restart();
    test_timeout();
    test_peer_lose();
    test_peer_reset();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer for the two-board "guess who" game. Produces `state_bin` and `your_person` for game_logic and consumes its `resoult` and `reset` outputs.
- Turns mouse clicks on the 3x3 portrait grid into a secret-person choice and a guess.
- Drives `rst_sys` so that both boards restart together.

Parameters:
- CHECK_TIMEOUT, 65_000_000, cycles to wait in CHECK for a result before returning to GUESS (1 s at 65 MHz).
- RST_PULSE_LEN, 16, cycles `rst_sys` is held high in RESTART (minimum 2).

Ports:
- clk  in  1  system clock (65 MHz pixel clock domain)
- rst  in  1  synchronous, active-high reset
- xpos  in  12  mouse x coordinate
- ypos  in  12  mouse y coordinate
- MouseLeft  in  1  left button level
- MouseRight  in  1  right button level
- resoult  in  2  from game_logic: 2'b10 win, 2'b01 lose, 2'b00 none
- reset  in  1  from game_logic: restart request relayed from peer board
- state_bin  out  6  one-hot game state
- your_person  out  4  chosen secret person, 1..9, 0 = none
- rst_sys  out  1  system/peer reset pulse

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`). Every register changes only on posedge `clk`.
- Reset values: `state_bin` = START (6'b000001), `your_person` = 0, `rst_sys` = 0, all counters 0, click-history flops 0.
- Click edges:
  - Register MouseLeft and MouseRight each cycle.
  - `l_click` = MouseLeft & ~MouseLeft_q; `r_click` = MouseRight & ~MouseRight_q.
  - Edges are evaluated combinationally in the same cycle, so the action takes effect at the next clock edge (latency 1).
  - A held button produces exactly one edge.
- Tile hit:
  - `tile_idx` (4 bit) is 1..9 when (xpos,ypos) lies inside a tile, else 0.
  - Tile n covers column c = (n-1)%3 and row r = (n-1)/3.
  - Inclusive bounds: X_c_DIM <= xpos <= X_c_DIM + A_side and Y_r_DIM <= ypos <= Y_r_DIM + B_side.
  - Where tiles overlap, the lowest index wins.
- States (one-hot on `state_bin`):
  - START 6'b000001, GUESS 6'b000010, CHECK 6'b000100, WIN 6'b001000, LOSE 6'b010000, RESTART 6'b100000.
- START: on `l_click` with `tile_idx` != 0, latch `your_person` = `tile_idx` and go to GUESS. Any other click is ignored.
- GUESS:
  - `r_click` with `tile_idx` != 0: go to CHECK. game_logic captures its guess on the same edge. Clear `chk_cnt`.
  - `resoult` == 2'b10: go to WIN; `resoult` == 2'b01: go to LOSE. This handles the peer guessing first.
  - If `r_click` and a non-zero `resoult` occur together, `resoult` has priority.
- CHECK:
  - `resoult` == 2'b10: go to WIN; `resoult` == 2'b01: go to LOSE.
  - Otherwise increment `chk_cnt`. When `chk_cnt` == CHECK_TIMEOUT-1, return to GUESS.
  - `your_person` is held.
- WIN / LOSE: terminal. On `l_click` (anywhere) go to RESTART and clear `rst_cnt`.
- RESTART:
  - `rst_sys` = 1 for exactly RST_PULSE_LEN cycles (registered output, high from the first RESTART cycle).
  - When `rst_cnt` == RST_PULSE_LEN-1, go to START, clear `your_person`, and drive `rst_sys` = 0 next cycle.
- Peer restart:
  - `reset` == 1 in any state except RESTART: go to START next cycle, clear `your_person`, clear counters.
  - `reset` is ignored in RESTART, so the block's own pulse echoed back cannot retrigger it.
- `rst` mid-operation has priority over everything and returns all outputs to reset values next cycle.
- Counter widths: `$clog2` of their limit, no wrap beyond the limit.
- Illegal or non-one-hot state: recover to START.

Decomposition:
- vga_pkg gets:
  - the state enum typedef `game_state_t` (6-bit one-hot values above);
  - constants RESULT_WIN = 2'b10 and RESULT_LOSE = 2'b01;
  - the existing X_*_DIM, Y_*_DIM, A_side and B_side, reused unchanged.
- One sub-module `tile_hit_decoder` (combinational: xpos, ypos -> `tile_idx`) so the same hit-test can be shared with other consumers.

Test Plan:
- Reset then idle: `rst` 1 for 2 cycles -> `state_bin` = 6'b000001, `your_person` = 0, `rst_sys` = 0; no state change with MouseLeft held high over a tile (no edge).
- START select: left-click rising edge at (X_2_DIM+1, Y_3_DIM+1) -> next cycle `your_person` = 4'd8, `state_bin` = 6'b000010; a click at (0,0) beforehand causes no change.
- Guess then win: in GUESS, right-click edge on tile 5 -> CHECK next cycle; drive `resoult` = 2'b10 three cycles later -> `state_bin` = 6'b001000 one cycle after.
- Check timeout: CHECK_TIMEOUT = 8, no `resoult` -> back to GUESS exactly 8 cycles after entering CHECK.
- Peer win in GUESS with simultaneous right click: `resoult` = 2'b01 and `r_click` in the same cycle -> LOSE, not CHECK.
- Restart: in WIN, left click -> `rst_sys` high for exactly RST_PULSE_LEN = 4 cycles, with `reset` = 1 echoed during RESTART ignored; then START with `your_person` = 0. `reset` = 1 while in GUESS -> START next cycle.
